// File: rtl/regfile_sched_pkg.sv
// Shared parameters and types for the register-file access scheduler.
package regfile_sched_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_MAX_STALL  = 3;

  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } rd_req_t;

  // wr/rd1/rd2 are ready-style grants: they do not depend on the port's own valid.
  // merge means both reads hit the same address and share read port 1.
  typedef struct packed {
    logic wr;
    logic rd1;
    logic rd2;
    logic merge;
  } grant_t;

endpackage

// File: rtl/regfile_grant_arb.sv
// Combinational conflict detection and grant for one write and two read requests.
module regfile_grant_arb
  import regfile_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd1_valid,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic                  rd2_valid,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  input  logic                  sat1,
  input  logic                  sat2,
  output grant_t                grant
);

  logic w_conf1;
  logic w_conf2;
  logic w_rd_over;

  // Writes win same-address conflicts unless a conflicting read has waited MAX_STALL cycles.
  // When both reads conflict (same address), one saturated counter lets both through.
  always_comb begin
    w_conf1   = wr_valid && rd1_valid && (wr_addr == rd1_addr);
    w_conf2   = wr_valid && rd2_valid && (wr_addr == rd2_addr);
    if (w_conf1 && w_conf2) begin
      w_rd_over = sat1 || sat2;
    end else begin
      w_rd_over = (w_conf1 && sat1) || (w_conf2 && sat2);
    end
    grant.wr    = !w_rd_over;
    grant.rd1   = !(w_conf1 && !w_rd_over);
    grant.rd2   = !(w_conf2 && !w_rd_over);
    grant.merge = rd1_valid && rd2_valid && (rd1_addr == rd2_addr) && !w_conf1 && !w_conf2;
  end

endmodule

// File: rtl/regfile_access_scheduler.sv
// Collision-free front end for a 2-read/1-write register file, with bounded read starvation.
module regfile_access_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_STALL  = DEF_MAX_STALL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_rvalid,
  output logic [DATA_WIDTH-1:0] rd1_rdata,
  input  logic                  rd2_valid,
  output logic                  rd2_ready,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic                  rd2_rvalid,
  output logic [DATA_WIDTH-1:0] rd2_rdata,
  output logic                  rf_wen1,
  output logic [ADDR_WIDTH-1:0] rf_wad1,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic                  rf_ren1,
  output logic [ADDR_WIDTH-1:0] rf_rad1,
  output logic                  rf_ren2,
  output logic [ADDR_WIDTH-1:0] rf_rad2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic                  proto_err
);

  localparam int CW = $clog2(MAX_STALL + 1);

  logic [CW-1:0] r_stall1;
  logic [CW-1:0] r_stall2;
  logic          r_rvalid1;
  logic          r_rvalid2;
  logic          r_merge_q;
  logic          r_proto_err;
  logic          w_sat1;
  logic          w_sat2;
  logic          w_acc1;
  logic          w_acc2;
  grant_t        w_gnt;

  assign w_sat1 = (r_stall1 == CW'(MAX_STALL));
  assign w_sat2 = (r_stall2 == CW'(MAX_STALL));

  regfile_grant_arb #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_arb (
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .rd1_valid(rd1_valid),
    .rd1_addr (rd1_addr),
    .rd2_valid(rd2_valid),
    .rd2_addr (rd2_addr),
    .sat1     (w_sat1),
    .sat2     (w_sat2),
    .grant    (w_gnt)
  );

  // Readies are held low during reset so nothing reaches the register file.
  assign wr_ready  = !reset && w_gnt.wr;
  assign rd1_ready = !reset && w_gnt.rd1;
  assign rd2_ready = !reset && w_gnt.rd2;
  assign w_acc1    = rd1_valid && rd1_ready;
  assign w_acc2    = rd2_valid && rd2_ready;

  assign rf_wen1 = wr_valid && wr_ready;
  assign rf_wad1 = wr_addr;
  assign rf_din  = wr_data;
  assign rf_ren1 = w_acc1;
  assign rf_rad1 = rd1_addr;
  assign rf_ren2 = w_acc2 && !w_gnt.merge;
  assign rf_rad2 = rd2_addr;

  // Per-port stall counters: count blocked cycles, clear on acceptance, hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall1 <= '0;
      r_stall2 <= '0;
    end else begin
      if (rd1_valid) begin
        if (rd1_ready)    r_stall1 <= '0;
        else if (!w_sat1) r_stall1 <= r_stall1 + CW'(1);
      end
      if (rd2_valid) begin
        if (rd2_ready)    r_stall2 <= '0;
        else if (!w_sat2) r_stall2 <= r_stall2 + CW'(1);
      end
    end
  end

  // Response pipeline: acceptance delayed one cycle, plus the port-2 fan-out select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid1 <= 1'b0;
      r_rvalid2 <= 1'b0;
      r_merge_q <= 1'b0;
    end else begin
      r_rvalid1 <= w_acc1;
      r_rvalid2 <= w_acc2;
      r_merge_q <= w_acc2 && w_gnt.merge;
    end
  end

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_proto_err <= 1'b0;
    else if (rf_collision) r_proto_err <= 1'b1;
  end

  assign rd1_rvalid = r_rvalid1;
  assign rd2_rvalid = r_rvalid2;
  assign rd1_rdata  = r_rvalid1 ? rf_dout1 : '0;
  assign rd2_rdata  = r_rvalid2 ? (r_merge_q ? rf_dout1 : rf_dout2) : '0;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_regfile_access_scheduler.sv
// Directed bench for regfile_access_scheduler with a behavioural 2R1W register file.
module tb_regfile_access_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd1_valid, rd1_ready, rd1_rvalid;
  logic [4:0]  rd1_addr;
  logic [15:0] rd1_rdata;
  logic        rd2_valid, rd2_ready, rd2_rvalid;
  logic [4:0]  rd2_addr;
  logic [15:0] rd2_rdata;
  logic        rf_wen1, rf_ren1, rf_ren2;
  logic [4:0]  rf_wad1, rf_rad1, rf_rad2;
  logic [15:0] rf_din;
  logic [15:0] m_dout1, m_dout2;
  logic        rf_collision;
  logic        force_coll;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_access_scheduler dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
    .rd1_rvalid(rd1_rvalid), .rd1_rdata(rd1_rdata),
    .rd2_valid(rd2_valid), .rd2_ready(rd2_ready), .rd2_addr(rd2_addr),
    .rd2_rvalid(rd2_rvalid), .rd2_rdata(rd2_rdata),
    .rf_wen1(rf_wen1), .rf_wad1(rf_wad1), .rf_din(rf_din),
    .rf_ren1(rf_ren1), .rf_rad1(rf_rad1), .rf_ren2(rf_ren2), .rf_rad2(rf_rad2),
    .rf_dout1(m_dout1), .rf_dout2(m_dout2),
    .rf_collision(rf_collision), .proto_err(proto_err)
  );

  // Register file model: read-before-write, entry i resets to 0x1000+i.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
    end else begin
      if (rf_wen1) mem[rf_wad1] <= rf_din;
      if (rf_ren1) m_dout1 <= mem[rf_rad1];
      if (rf_ren2) m_dout2 <= mem[rf_rad2];
    end
  end

  assign rf_collision = force_coll ||
    (rf_wen1 && ((rf_ren1 && rf_rad1 == rf_wad1) || (rf_ren2 && rf_rad2 == rf_wad1)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        r1v;
    logic [4:0]  r1a;
    logic        r2v;
    logic [4:0]  r2a;
    logic        e_wr, e_r1, e_r2, e_ren2, e_rv1, e_rv2;
    logic [15:0] e_d1, e_d2;
  } vec_t;

  function automatic vec_t mk(logic wv, logic [4:0] wa, logic [15:0] wd,
                              logic r1v, logic [4:0] r1a, logic r2v, logic [4:0] r2a,
                              logic e_wr, logic e_r1, logic e_r2, logic e_ren2,
                              logic e_rv1, logic [15:0] e_d1, logic e_rv2, logic [15:0] e_d2);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.r1v = r1v; v.r1a = r1a; v.r2v = r2v; v.r2a = r2a;
    v.e_wr = e_wr; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_ren2 = e_ren2;
    v.e_rv1 = e_rv1; v.e_d1 = e_d1; v.e_rv2 = e_rv2; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic drive(logic wv, logic [4:0] wa, logic [15:0] wd,
                       logic r1v, logic [4:0] r1a, logic r2v, logic [4:0] r2a);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd1_valid = r1v; rd1_addr = r1a; rd2_valid = r2v; rd2_addr = r2a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    // Each row: inputs for this cycle, expected readies/rf_ren2 this cycle,
    // and expected response beat for reads accepted in the previous row.
    vecs[0] = mk(1, 3, 16'h00AA, 0, 0, 0, 0,  1, 1, 1, 0,  0, 16'h0, 0, 16'h0);
    vecs[1] = mk(0, 0, 16'h0,    1, 3, 1, 4,  1, 1, 1, 1,  0, 16'h0, 0, 16'h0);
    vecs[2] = mk(1, 9, 16'h0055, 0, 0, 0, 0,  1, 1, 1, 0,  1, 16'h00AA, 1, 16'h1004);
    vecs[3] = mk(1, 7, 16'h1234, 1, 7, 0, 0,  1, 0, 1, 0,  0, 16'h0, 0, 16'h0);
    vecs[4] = mk(0, 0, 16'h0,    1, 7, 0, 0,  1, 1, 1, 0,  0, 16'h0, 0, 16'h0);
    vecs[5] = mk(0, 0, 16'h0,    1, 9, 1, 9,  1, 1, 1, 0,  1, 16'h1234, 0, 16'h0);
    vecs[6] = mk(0, 0, 16'h0,    0, 0, 0, 0,  1, 1, 1, 0,  1, 16'h0055, 1, 16'h0055);
    vecs[7] = mk(1, 10, 16'hBEEF, 1, 11, 1, 10, 1, 1, 0, 0, 0, 16'h0, 0, 16'h0);
    vecs[8] = mk(0, 0, 16'h0,    0, 0, 1, 10, 1, 1, 1, 1,  1, 16'h100B, 0, 16'h0);
    vecs[9] = mk(0, 0, 16'h0,    0, 0, 0, 0,  1, 1, 1, 0,  0, 16'h0, 1, 16'hBEEF);

    force_coll = 1'b0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd1_ready", 32'(rd1_ready), 0);
    chk("rst_rvalid1", 32'(rd1_rvalid), 0);
    chk("rst_rvalid2", 32'(rd2_rvalid), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    next_cycle();
    reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(vecs[k].wv, vecs[k].wa, vecs[k].wd, vecs[k].r1v, vecs[k].r1a, vecs[k].r2v, vecs[k].r2a);
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", k), 32'(wr_ready), 32'(vecs[k].e_wr));
      chk($sformatf("v%0d_rd1_ready", k), 32'(rd1_ready), 32'(vecs[k].e_r1));
      chk($sformatf("v%0d_rd2_ready", k), 32'(rd2_ready), 32'(vecs[k].e_r2));
      chk($sformatf("v%0d_rf_ren2", k), 32'(rf_ren2), 32'(vecs[k].e_ren2));
      chk($sformatf("v%0d_rvalid1", k), 32'(rd1_rvalid), 32'(vecs[k].e_rv1));
      chk($sformatf("v%0d_rvalid2", k), 32'(rd2_rvalid), 32'(vecs[k].e_rv2));
      chk($sformatf("v%0d_rdata1", k), 32'(rd1_rdata), 32'(vecs[k].e_d1));
      chk($sformatf("v%0d_rdata2", k), 32'(rd2_rdata), 32'(vecs[k].e_d2));
    end

    // Starvation bound: continuous write to addr 5 against a read of addr 5.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(1, 5, 16'h5000 + 16'(k), 1, 5, 0, 0);
      @(negedge clk);
      chk($sformatf("starve%0d_rd1_ready", k), 32'(rd1_ready), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d_wr_ready", k), 32'(wr_ready), (k == 3) ? 32'd0 : 32'd1);
      chk($sformatf("starve%0d_wen1", k), 32'(rf_wen1), (k == 3) ? 32'd0 : 32'd1);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("starve_rvalid1", 32'(rd1_rvalid), 1);
    chk("starve_old_data", 32'(rd1_rdata), 32'h5002);
    next_cycle();
    drive(1, 5, 16'h6000, 1, 5, 0, 0);
    @(negedge clk);
    chk("cnt_cleared_rd1_ready", 32'(rd1_ready), 0);
    chk("cnt_cleared_wr_ready", 32'(wr_ready), 1);
    next_cycle();
    drive(0, 0, 0, 1, 5, 0, 0);
    @(negedge clk);
    chk("retry_rd1_ready", 32'(rd1_ready), 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("retry_rdata1", 32'(rd1_rdata), 32'h6000);

    // Reset while a read response is outstanding.
    next_cycle();
    drive(0, 0, 0, 1, 3, 0, 0);
    @(negedge clk);
    chk("pre_rst_rd1_ready", 32'(rd1_ready), 1);
    next_cycle();
    reset = 1'b1;
    drive(1, 2, 16'h7777, 0, 0, 1, 8);
    @(negedge clk);
    chk("midrst_rvalid1", 32'(rd1_rvalid), 0);
    chk("midrst_rdata1", 32'(rd1_rdata), 0);
    chk("midrst_wr_ready", 32'(wr_ready), 0);
    chk("midrst_rd1_ready", 32'(rd1_ready), 0);
    chk("midrst_rd2_ready", 32'(rd2_ready), 0);
    chk("midrst_wen1", 32'(rf_wen1), 0);
    chk("midrst_ren2", 32'(rf_ren2), 0);
    chk("midrst_proto_err", 32'(proto_err), 0);
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postrst_rvalid1", 32'(rd1_rvalid), 0);
    chk("postrst_rvalid2", 32'(rd2_rvalid), 0);
    chk("postrst_proto_err", 32'(proto_err), 0);

    // Forced collision sets the sticky error one cycle later.
    next_cycle();
    force_coll = 1'b1;
    @(negedge clk);
    chk("coll_same_cycle", 32'(proto_err), 0);
    next_cycle();
    force_coll = 1'b0;
    @(negedge clk);
    chk("coll_next_cycle", 32'(proto_err), 1);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("coll_sticky%0d", k), 32'(proto_err), 1);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("coll_cleared_by_reset", 32'(proto_err), 0);
    next_cycle();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
